booth_seq_mul: RTL and testbench

BOOTH_SEQ_MUL -- requirements
Module: booth_seq_mul

---
 rtl/booth_pkg.sv | 39 +++
 rtl/booth_r4_pp.sv | 33 +++
 rtl/booth_seq_mul.sv | 143 ++++++++++++++
 tb/tb_booth_seq_mul.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg -- shared definitions for the sequential radix-4 Booth multiplier.
//   state_t      : controller states (IDLE, CALC, DONE)
//   SEL_*        : partial-product selection codes {negate, two, one}
//   booth_sel()  : maps a 3-bit Booth group to a selection code
//   calc_n()     : number of CALC cycles for a given operand width
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit 2 negates, bit 1 selects 2a, bit 0 selects a.
  localparam logic [2:0] SEL_ZERO = 3'b000;
  localparam logic [2:0] SEL_POS1 = 3'b001;
  localparam logic [2:0] SEL_POS2 = 3'b010;
  localparam logic [2:0] SEL_NEG1 = 3'b101;
  localparam logic [2:0] SEL_NEG2 = 3'b110;

  // Group is {b[2i+1], b[2i], b[2i-1]}.
  function automatic logic [2:0] booth_sel(input logic [2:0] group);
    logic [2:0] sel;
    case (group)
      3'b001, 3'b010: sel = SEL_POS1;
      3'b011:         sel = SEL_POS2;
      3'b100:         sel = SEL_NEG2;
      3'b101, 3'b110: sel = SEL_NEG1;
      default:        sel = SEL_ZERO;
    endcase
    return sel;
  endfunction

  // Operands are extended by two bits, giving (WIDTH+2)/2 Booth groups.
  function automatic int calc_n(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_pp.sv
// booth_r4_pp -- combinational radix-4 Booth partial-product selector.
//   group : 3-bit Booth group of the multiplier
//   a_ext : extended (two's complement) multiplicand, EW bits
//   pp    : selected partial product {0, +-a, +-2a}, EW+1 bits, signed
module booth_r4_pp
  import booth_pkg::*;
#(
  parameter int EW = 34
) (
  input  logic [2:0]  group,
  input  logic [EW-1:0] a_ext,
  output logic [EW:0] pp
);

  logic [2:0]  sel;
  logic [EW:0] a_one;
  logic [EW:0] a_two;
  logic [EW:0] mag;

  assign sel   = booth_sel(group);
  assign a_one = {a_ext[EW-1], a_ext};
  assign a_two = {a_ext, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi <= EW; gi++) begin : g_mag
      assign mag[gi] = (sel[0] & a_one[gi]) | (sel[1] & a_two[gi]);
    end
  endgenerate

  assign pp = sel[2] ? -mag : mag;

endmodule

// File: rtl/booth_seq_mul.sv
// booth_seq_mul -- sequential radix-4 Booth multiplier, one group per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, a_signed, b_signed)
//   out_valid / out_ready: result handshake (prod_msb, prod_lsb)
//   busy                 : high whenever the controller is not IDLE
// Optional macro BOOTH_ZERO_BYPASS_EN: a zero operand skips CALC and the
// result (0) is presented one edge after acceptance.
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             a_signed,
  input  logic             b_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod_msb,
  output logic [WIDTH-1:0] prod_lsb,
  output logic             busy
);

  localparam int EW = WIDTH + 2;  // extended operand width
  localparam int HW = WIDTH + 4;  // upper accumulator with headroom for +-2a
  localparam int N  = calc_n(WIDTH);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [HW-1:0]    hi_reg;
  logic [EW-1:0]    lo_reg;   // multiplier, shifted out as product bits shift in
  logic             qm1_reg;  // implicit b[-1] of the current group
  logic [EW-1:0]    a_reg;
  logic [WIDTH-1:0] prod_msb_reg;
  logic [WIDTH-1:0] prod_lsb_reg;
  logic             out_valid_reg;

  logic [EW-1:0]    a_ext;
  logic [EW-1:0]    b_ext;
  logic [EW:0]      pp;
  logic [HW-1:0]    sum_next;
  logic [HW-1:0]    hi_next;
  logic [EW-1:0]    lo_next;
  logic [WIDTH-1:0] prod_msb_next;
  logic [WIDTH-1:0] prod_lsb_next;

  assign a_ext = {{2{a_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{2{b_signed & b[WIDTH-1]}}, b};

  booth_r4_pp #(.EW(EW)) u_pp (
    .group (lo_reg[1:0] == 2'b00 && !qm1_reg ? 3'b000 : {lo_reg[1:0], qm1_reg}),
    .a_ext (a_reg),
    .pp    (pp)
  );

  // Add the partial product, then shift {hi, lo} right arithmetically by 2.
  assign sum_next = hi_reg + {{(HW-EW-1){pp[EW]}}, pp};
  assign hi_next  = {{2{sum_next[HW-1]}}, sum_next[HW-1:2]};
  assign lo_next  = {sum_next[1:0], lo_reg[EW-1:2]};

  // After the last step the low 2*WIDTH product bits span lo and the bottom of hi.
  assign prod_lsb_next = lo_next[WIDTH-1:0];
  assign prod_msb_next = {hi_next[WIDTH-3:0], lo_next[EW-1:WIDTH]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      qm1_reg       <= 1'b0;
      a_reg         <= '0;
      prod_msb_reg  <= '0;
      prod_lsb_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a_ext;
            hi_reg  <= '0;
            lo_reg  <= b_ext;
            qm1_reg <= 1'b0;
            cnt_reg <= '0;
`ifdef BOOTH_ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              // out_valid is raised on the following edge from DONE.
              state_reg    <= DONE;
              prod_msb_reg <= '0;
              prod_lsb_reg <= '0;
            end else begin
              state_reg <= CALC;
            end
`else
            state_reg <= CALC;
`endif
          end
        end
        CALC: begin
          hi_reg  <= hi_next;
          lo_reg  <= lo_next;
          qm1_reg <= lo_reg[1];
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            state_reg     <= DONE;
            cnt_reg       <= '0;
            out_valid_reg <= 1'b1;
            prod_msb_reg  <= prod_msb_next;
            prod_lsb_reg  <= prod_lsb_next;
          end
        end
        DONE: begin
          if (out_valid_reg) begin
            // Return to IDLE only; acceptance waits for the next edge.
            if (out_ready) begin
              state_reg     <= IDLE;
              out_valid_reg <= 1'b0;
            end
          end
`ifdef BOOTH_ZERO_BYPASS_EN
          else begin
            out_valid_reg <= 1'b1;
          end
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = out_valid_reg;
  assign prod_msb  = prod_msb_reg;
  assign prod_lsb  = prod_lsb_reg;

endmodule

// File: tb/tb_booth_seq_mul.sv
// tb_booth_seq_mul -- self-checking bench for booth_seq_mul (WIDTH = 32).
// Expected products come from a wide signed multiply of the extended
// operands; expected latency is 17 edges (1 for zero operands when
// BOOTH_ZERO_BYPASS_EN is defined).
module tb_booth_seq_mul;

  localparam int W = 32;
  localparam int N = 17;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         a_signed = 1'b0;
  logic         b_signed = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] prod_msb;
  logic [W-1:0] prod_lsb;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_seq_mul #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .a_signed  (a_signed),
    .b_signed  (b_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod_msb  (prod_msb),
    .prod_lsb  (prod_lsb),
    .busy      (busy)
  );

  // Reference: exact product of the operands as the modes interpret them.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic xs, input logic ys);
    logic signed [65:0] xe;
    logic signed [65:0] ye;
    logic signed [65:0] pr;
    xe = xs ? {{34{x[31]}}, x} : {34'd0, x};
    ye = ys ? {{34{y[31]}}, y} : {34'd0, y};
    pr = xe * ye;
    return pr[63:0];
  endfunction

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef BOOTH_ZERO_BYPASS_EN
    if (x == 0 || y == 0) return 1;
`endif
    return N;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation from IDLE; returns edges from acceptance to out_valid
  // (-1 on timeout) and the presented product. Leaves out_ready low.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic xs, input logic ys,
                        output int lat, output logic [63:0] p);
    int guard;
    guard = 0;
    out_ready = 1'b0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    a = x; b = y; a_signed = xs; b_signed = ys; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs while the operation runs.
    a = $urandom; b = $urandom;
    a_signed = 1'($urandom_range(0, 1));
    b_signed = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    p = {prod_msb, prod_lsb};
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_flags: got rdy/busy/ov=%b expected 100", {in_ready, busy, out_valid});
    end
    n_vec++;
    if ({prod_msb, prod_lsb} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_prod: got %h expected 0", {prod_msb, prod_lsb});
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_directed();
    logic [31:0] xa [6];
    logic [31:0] xb [6];
    logic [1:0]  md [6];
    logic [63:0] ex [6];
    int lat;
    logic [63:0] p;
    xa[0] = 32'd15;        xb[0] = 32'd3;          md[0] = 2'b00; ex[0] = 64'h00000000_0000002D;
    xa[1] = 32'hFFFFFFFF;  xb[1] = 32'd2;          md[1] = 2'b00; ex[1] = 64'h00000001_FFFFFFFE;
    xa[2] = -32'sd10;      xb[2] = 32'd20;         md[2] = 2'b11; ex[2] = 64'hFFFFFFFF_FFFFFF38;
    xa[3] = 32'd32768;     xb[3] = -32'sd32768;    md[3] = 2'b11; ex[3] = 64'hFFFFFFFF_C0000000;
    xa[4] = 32'hFFFFFFFF;  xb[4] = 32'hFFFFFFFF;   md[4] = 2'b10; ex[4] = 64'hFFFFFFFF_00000001;
    xa[5] = 32'h80000000;  xb[5] = 32'h80000000;   md[5] = 2'b11; ex[5] = 64'h40000000_00000000;
    for (int i = 0; i < 6; i++) begin
      // The first op is issued right after reset release: must be accepted at once.
      run_op(xa[i], xb[i], md[i][1], md[i][0], lat, p);
      $display("directed %0d: %h * %h mode=%b -> %h lat=%0d", i, xa[i], xb[i], md[i], p, lat);
      n_vec++;
      if (lat != N) begin
        n_err++;
        $display("FAIL directed_lat[%0d]: got %0d expected %0d", i, lat, N);
      end
      n_vec++;
      if (p !== ex[i]) begin
        n_err++;
        $display("FAIL directed_prod[%0d]: got %h expected %h", i, p, ex[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_random();
    int lat;
    int wait_cyc;
    logic [63:0] p;
    logic [63:0] e;
    logic [31:0] x;
    logic [31:0] y;
    logic xs;
    logic ys;
    for (int i = 0; i < 40; i++) begin
      x = pick_operand();
      y = pick_operand();
      xs = 1'($urandom_range(0, 1));
      ys = 1'($urandom_range(0, 1));
      e = ref_mul(x, y, xs, ys);
      run_op(x, y, xs, ys, lat, p);
      $display("random %0d: %h * %h s=%b%b -> %h lat=%0d", i, x, y, xs, ys, p, lat);
      n_vec++;
      if (lat != exp_lat(x, y)) begin
        n_err++;
        $display("FAIL random_lat[%0d]: got %0d expected %0d", i, lat, exp_lat(x, y));
      end
      n_vec++;
      if (p !== e) begin
        n_err++;
        $display("FAIL random_prod[%0d]: got %h expected %h", i, p, e);
      end
      wait_cyc = $urandom_range(0, 3);
      for (int k = 0; k < wait_cyc; k++) begin
        @(posedge clk); #1;
      end
      finish_op();
      n_vec++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
        n_err++;
        $display("FAIL random_after_hs[%0d]: got ov/rdy/busy=%b expected 010", i, {out_valid, in_ready, busy});
      end
    end
  endtask

  // Stall in DONE, then offer a new op during the handshake edge.
  task automatic test_backpressure();
    int lat;
    logic [63:0] p;
    logic [63:0] e;
    logic [63:0] e2;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] nx;
    logic [31:0] ny;
    x = $urandom | 32'h1; y = $urandom | 32'h1;
    e = ref_mul(x, y, 1'b1, 1'b0);
    nx = $urandom | 32'h1; ny = $urandom | 32'h1;
    e2 = ref_mul(nx, ny, 1'b0, 1'b1);
    run_op(x, y, 1'b1, 1'b0, lat, p);
    $display("backpressure: %h * %h -> %h lat=%0d", x, y, p, lat);
    n_vec++;
    if (p !== e) begin
      n_err++;
      $display("FAIL bp_prod: got %h expected %h", p, e);
    end
    a = nx; b = ny; a_signed = 1'b0; b_signed = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({out_valid, in_ready, prod_msb, prod_lsb} !== {2'b10, e}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got ov=%b rdy=%b prod=%h expected ov=1 rdy=0 prod=%h",
                 k, out_valid, in_ready, {prod_msb, prod_lsb}, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_vec++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL bp_handshake: got ov/busy/rdy=%b expected 001", {out_valid, busy, in_ready});
    end
    n_vec++;
    if ({prod_msb, prod_lsb} !== e) begin
      n_err++;
      $display("FAIL bp_retain: got %h expected %h", {prod_msb, prod_lsb}, e);
    end
    // in_valid is still high: accepted on this edge (back-to-back).
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("back_to_back: %h * %h -> %h lat=%0d", nx, ny, {prod_msb, prod_lsb}, lat);
    n_vec++;
    if (lat != N) begin
      n_err++;
      $display("FAIL b2b_lat: got %0d expected %0d", lat, N);
    end
    n_vec++;
    if ({prod_msb, prod_lsb} !== e2) begin
      n_err++;
      $display("FAIL b2b_prod: got %h expected %h", {prod_msb, prod_lsb}, e2);
    end
    finish_op();
  endtask

  task automatic test_reset_mid_calc();
    int pulses;
    int lat;
    logic [63:0] p;
    a = 32'd12345; b = 32'd678; a_signed = 1'b0; b_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL midcalc_busy: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, in_ready, out_valid, prod_msb, prod_lsb} !== {3'b010, 64'd0}) begin
      n_err++;
      $display("FAIL midcalc_reset: got busy/rdy/ov=%b prod=%h expected 010 prod=0",
               {busy, in_ready, out_valid}, {prod_msb, prod_lsb});
    end
    #2;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    $display("reset mid-calc: out_valid pulses after reset=%0d", pulses);
    n_vec++;
    if (pulses != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midcalc_discard: got pulses=%0d busy=%b expected 0 0", pulses, busy);
    end
    run_op(32'd7, 32'd9, 1'b0, 1'b0, lat, p);
    $display("post-reset op: 7 * 9 -> %h lat=%0d", p, lat);
    n_vec++;
    if (lat != N || p !== 64'd63) begin
      n_err++;
      $display("FAIL post_reset_op: got lat=%0d prod=%h expected %0d 3f", lat, p, N);
    end
    finish_op();
  endtask

  task automatic test_zero_operands();
    int lat;
    logic [63:0] p;
    logic [31:0] x;
    run_op(32'd0, 32'h12345678, 1'b0, 1'b0, lat, p);
    $display("zero a: 0 * 12345678 -> %h lat=%0d", p, lat);
    n_vec++;
    if (lat != exp_lat(32'd0, 32'h12345678) || p !== 64'd0) begin
      n_err++;
      $display("FAIL zero_a: got lat=%0d prod=%h expected %0d 0", lat, p, exp_lat(32'd0, 32'h12345678));
    end
    finish_op();
    x = $urandom | 32'h8000_0000;
    run_op(x, 32'd0, 1'b1, 1'b1, lat, p);
    $display("zero b: %h * 0 -> %h lat=%0d", x, p, lat);
    n_vec++;
    if (lat != exp_lat(x, 32'd0) || p !== 64'd0) begin
      n_err++;
      $display("FAIL zero_b: got lat=%0d prod=%h expected %0d 0", lat, p, exp_lat(x, 32'd0));
    end
    finish_op();
    run_op(32'd3, 32'h12345678, 1'b0, 1'b0, lat, p);
    $display("nonzero after zero: 3 * 12345678 -> %h lat=%0d", p, lat);
    n_vec++;
    if (lat != N || p !== 64'h00000000_369D0368) begin
      n_err++;
      $display("FAIL nonzero_lat: got lat=%0d prod=%h expected %0d 369d0368", lat, p, N);
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_calc();
    test_zero_operands();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
